// File: rtl/ica_pkg.sv
// Shared types and constants for the ICA datapath (frame loader, pe2, pe2_33).
// No ports; provides sample/vector/frame typedefs and the loader write-state enum.
package ica_pkg;

   localparam int W      = 32;
   localparam int N_CH   = 3;
   localparam int N_SAMP = 64;
   localparam int IDX_W  = $clog2(N_SAMP);

   typedef logic signed [W-1:0]                     sample_t;
   typedef sample_t [0:N_CH-1]                      vec_t;
   typedef sample_t [0:N_CH-1][0:N_SAMP-1]          frame_t;

   typedef enum logic {
      FILL  = 1'b0,
      STALL = 1'b1
   } wr_state_t;

endpackage

// File: rtl/ica_frame_bank.sv
// One N_CH x N_SAMP sample bank with a FULL flag.
// Ports:
//   clk, rst      clock, asynchronous active-low reset (clears the flag only)
//   wr_en, idx    write enable and sample index for data
//   data          one sample per channel
//   set_full      marks the bank FULL (wins over clr_full)
//   clr_full      marks the bank EMPTY
//   mem           bank contents
//   full          FULL flag
module ica_frame_bank
   import ica_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] idx,
   input  vec_t             data,
   input  logic             set_full,
   input  logic             clr_full,
   output frame_t           mem,
   output logic             full
);

   // Storage is deliberately not reset; a bank is only meaningful once FULL.
   // A FULL bank is never written so the consumer sees a frozen frame.
   always_ff @(posedge clk) begin
      if (wr_en && !full) begin
         for (int ch = 0; ch < N_CH; ch++) begin
            mem[ch][idx] <= data[ch];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         full <= 1'b0;
      end else if (set_full) begin
         full <= 1'b1;
      end else if (clr_full) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/ica_frame_loader.sv
// Ping-pong frame loader: collects N_SAMP vectors of N_CH samples into one of
// two banks and presents each completed frame until acknowledged.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   s_valid/s_ready/s_data   input sample stream
//   u             frame from the read bank, 0 while frame_valid=0
//   frame_valid   u holds a complete frame
//   frame_ack     consumer has taken u
//   fill_level    samples in the current write bank
//   frames_done   acknowledged frame count (wraps)
//
// state | meaning
// FILL  | write bank accepting samples whenever it is not FULL
// STALL | both banks FULL, input held off until an ack frees one
module ica_frame_loader
   import ica_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  vec_t             s_data,
   output frame_t           u,
   output logic             frame_valid,
   input  logic             frame_ack,
   output logic [IDX_W:0]   fill_level,
   output logic [15:0]      frames_done
);

   wr_state_t        state, state_nx;
   logic             wr_sel, rd_sel;
   logic             run;
   logic [IDX_W-1:0] idx;
   logic [1:0]       full;
   frame_t           bank_mem [2];
   logic             beat, last_beat, ack_fire, nxt_free;

   assign frame_valid = full[rd_sel];
   assign ack_fire    = frame_ack && frame_valid;
   assign beat        = s_valid && s_ready;
   assign last_beat   = beat && (idx == IDX_W'(N_SAMP - 1));
   // The bank we switch to after a completing beat is usable if it is empty
   // now or is being released by an ack on this same edge.
   assign nxt_free    = !full[!wr_sel] || (ack_fire && (rd_sel != wr_sel));

   assign fill_level  = {1'b0, idx};
   assign u           = frame_valid ? bank_mem[rd_sel] : '0;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      ica_frame_bank u_bank (
         .clk      (clk),
         .rst      (rst),
         .wr_en    (beat && (wr_sel == 1'(b))),
         .idx      (idx),
         .data     (s_data),
         .set_full (last_beat && (wr_sel == 1'(b))),
         .clr_full (ack_fire && (rd_sel == 1'(b))),
         .mem      (bank_mem[b]),
         .full     (full[b])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FILL;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         FILL:    if (last_beat && !nxt_free) state_nx = STALL;
         STALL:   if (ack_fire) state_nx = FILL;
         default: state_nx = FILL;
      endcase
   end

   // run holds s_ready low until the first clock after reset release.
   always_comb begin
      s_ready = 1'b0;
      if (run && (state == FILL)) begin
         s_ready = !full[wr_sel];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run         <= 1'b0;
         wr_sel      <= 1'b0;
         rd_sel      <= 1'b0;
         idx         <= '0;
         frames_done <= '0;
      end else begin
         run <= 1'b1;
         if (beat) begin
            idx <= last_beat ? '0 : idx + IDX_W'(1);
         end
         if (last_beat) begin
            wr_sel <= !wr_sel;
         end
         if (ack_fire) begin
            rd_sel      <= !rd_sel;
            frames_done <= frames_done + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_ica_frame_loader.sv
// Directed bench for ica_frame_loader. A queue-of-frames model predicts all
// outputs; every cycle the DUT is compared against it on the falling edge.
module tb_ica_frame_loader;
   import ica_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             s_valid = 1'b0;
   logic             frame_ack = 1'b0;
   vec_t             s_data = '0;
   logic             s_ready;
   logic             frame_valid;
   frame_t           u;
   logic [IDX_W:0]   fill_level;
   logic [15:0]      frames_done;

   int n_checks = 0;
   int n_pass   = 0;

   ica_frame_loader dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .u           (u),
      .frame_valid (frame_valid),
      .frame_ack   (frame_ack),
      .fill_level  (fill_level),
      .frames_done (frames_done)
   );

   always #5 clk = ~clk;

   // ---------------- model ----------------
   frame_t      m_q [$];     // completed frames, oldest first
   frame_t      m_cur;       // frame being collected
   int          m_cnt = 0;
   logic [15:0] m_fdone = '0;
   bit          m_run = 0;
   bit          m_beat = 0;

   task automatic model_reset();
      m_q.delete();
      m_cnt   = 0;
      m_fdone = '0;
      m_run   = 0;
      m_beat  = 0;
   endtask

   task automatic model_update();
      bit rdy, vld, ack_f;
      if (!rst) begin
         model_reset();
         return;
      end
      rdy    = m_run && (m_q.size() < 2);
      vld    = (m_q.size() > 0);
      ack_f  = frame_ack && vld;
      m_beat = s_valid && rdy;
      if (ack_f) begin
         void'(m_q.pop_front());
         m_fdone = m_fdone + 16'd1;
      end
      if (m_beat) begin
         for (int ch = 0; ch < N_CH; ch++) m_cur[ch][m_cnt] = s_data[ch];
         m_cnt++;
         if (m_cnt == N_SAMP) begin
            m_q.push_back(m_cur);
            m_cnt = 0;
         end
      end
      m_run = 1;
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic chk_u(input frame_t exp);
      bit found = 0;
      n_checks++;
      if (u === exp) n_pass++;
      else begin
         for (int ch = 0; ch < N_CH && !found; ch++)
            for (int k = 0; k < N_SAMP && !found; k++)
               if (u[ch][k] !== exp[ch][k]) begin
                  $display("FAIL u[%0d][%0d]: got %0d expected %0d (t=%0t)",
                           ch, k, u[ch][k], exp[ch][k], $time);
                  found = 1;
               end
         if (!found) $display("FAIL u: frame differs (t=%0t)", $time);
      end
   endtask

   task automatic check_all();
      frame_t exp_u;
      bit     exp_rdy;
      exp_u   = (m_q.size() > 0) ? m_q[0] : '0;
      exp_rdy = m_run && (m_q.size() < 2);
      chk("s_ready", s_ready, exp_rdy);
      chk("frame_valid", frame_valid, m_q.size() > 0);
      chk("fill_level", fill_level, m_cnt);
      chk("frames_done", frames_done, m_fdone);
      chk_u(exp_u);
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input int k);
      s_data[0] = sample_t'(k);
      s_data[1] = sample_t'(-k);
      s_data[2] = sample_t'(2 * k);
   endtask

   task automatic send(input int k0, input int n);
      for (int i = 0; i < n; i++) begin
         int guard = 0;
         drive(k0 + i);
         s_valid = 1'b1;
         do begin
            tick();
            guard++;
         end while (!m_beat && guard < 100);
         if (!m_beat) begin
            n_checks++;
            $display("FAIL send timeout: beat %0d not accepted in %0d cycles", k0 + i, guard);
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic reset_on();
      s_valid   = 1'b0;
      frame_ack = 1'b0;
      rst       = 1'b0;
      #1;
      model_reset();
      check_all();
   endtask

   task automatic reset_release();
      tick();
      tick();
      rst = 1'b1;
      tick();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int  k;
      int  cyc;
      bit  rdy_drop;

      @(negedge clk);

      // Reset state
      reset_on();
      chk("rst s_ready", s_ready, 0);
      chk("rst frame_valid", frame_valid, 0);
      chk("rst fill_level", fill_level, 0);
      chk("rst frames_done", frames_done, 0);
      chk_u('0);
      reset_release();
      chk("post-rst s_ready", s_ready, 1);

      // Spurious ack with nothing to acknowledge
      frame_ack = 1'b1;
      tick();
      tick();
      frame_ack = 1'b0;
      chk("spurious frames_done", frames_done, 0);
      chk("spurious frame_valid", frame_valid, 0);

      // Single frame; frame_valid one cycle after the last beat
      send(0, 63);
      chk("pre-last frame_valid", frame_valid, 0);
      chk("pre-last fill_level", fill_level, 63);
      send(63, 1);
      chk("single frame_valid", frame_valid, 1);
      chk("single u[0][5]", u[0][5], 5);
      chk("single u[1][5]", u[1][5], -5);
      chk("single u[2][63]", u[2][63], 126);
      chk("single fill_level", fill_level, 0);
      chk("model u[0][5]", m_q[0][0][5], 5);
      chk("model u[2][63]", m_q[0][2][63], 126);

      // Double-full stall
      send(64, 64);
      chk("stall s_ready", s_ready, 0);
      chk("stall u[0][0]", u[0][0], 0);
      drive(128);
      s_valid = 1'b1;
      tick();
      tick();
      tick();
      chk("held fill_level", fill_level, 0);
      chk("model held beat", m_beat, 0);
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      chk("after ack s_ready", s_ready, 1);
      chk("after ack u[0][0]", u[0][0], 64);
      chk("after ack u[2][63]", u[2][63], 254);
      chk("after ack frames_done", frames_done, 1);
      tick();
      chk("held beat written fill_level", fill_level, 1);
      s_valid = 1'b0;

      // Reset mid-fill (one FULL bank plus 40 partial samples)
      send(129, 39);
      chk("mid-fill fill_level", fill_level, 40);
      reset_on();
      chk("mid rst frame_valid", frame_valid, 0);
      chk("mid rst fill_level", fill_level, 0);
      chk("mid rst frames_done", frames_done, 0);
      chk_u('0);
      reset_release();
      send(500, 64);
      chk("fresh frame_valid", frame_valid, 1);
      chk("fresh u[0][0]", u[0][0], 500);
      chk("fresh u[1][39]", u[1][39], -539);
      chk("fresh u[2][63]", u[2][63], 1126);

      // Completing beat and ack on the same edge
      reset_on();
      reset_release();
      send(0, 64);
      send(64, 63);
      drive(127);
      s_valid   = 1'b1;
      frame_ack = 1'b1;
      tick();
      s_valid   = 1'b0;
      frame_ack = 1'b0;
      chk("simul frame_valid", frame_valid, 1);
      chk("simul u[0][0]", u[0][0], 64);
      chk("simul u[2][63]", u[2][63], 254);
      chk("simul s_ready", s_ready, 1);
      chk("simul fill_level", fill_level, 0);
      chk("simul frames_done", frames_done, 1);

      // Streaming: ack in the cycle each frame appears
      reset_on();
      reset_release();
      k        = 0;
      cyc      = 0;
      rdy_drop = 0;
      drive(k);
      s_valid = 1'b1;
      while (m_fdone < 16'd10 && cyc < 2000) begin
         frame_ack = (m_q.size() > 0);
         tick();
         if (s_ready !== 1'b1) rdy_drop = 1;
         if (m_beat) begin
            k++;
            drive(k);
         end
         cyc++;
      end
      s_valid   = 1'b0;
      frame_ack = 1'b0;
      if (cyc >= 2000) begin
         n_checks++;
         $display("FAIL stream timeout: %0d frames acked after %0d cycles", m_fdone, cyc);
      end
      chk("stream s_ready held", rdy_drop, 0);
      chk("stream frames_done", frames_done, 10);
      chk("stream frame_valid", frame_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ica_frame_loader.md
Name: ica_frame_loader

Overview:
- Builds the 3x64 signed-sample frame u[0:2][0:63] consumed by the uxuT correlation engine (pe2_33) and its pe2 dot-product units.
- Ingests one 3-channel sample vector per beat over a valid/ready stream into ping-pong register banks.
- Presents a completed frame with frame_valid until the consumer returns frame_ack.
- Sits between the ADC/centering front end and the ICA correlation stage, decoupling sample arrival from frame processing.

Parameters:
W, 32, sample width in bits (signed, two's complement)
N_CH, 3, channels per sample vector
N_SAMP, 64, samples per frame (power of two)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
s_valid  input  1  sample vector present on s_data
s_ready  output  1  loader can accept a vector this cycle
s_data  input  N_CH x W signed  one sample per channel, index 0..N_CH-1
u  output  N_CH x N_SAMP x W signed  frame from the read bank; u[ch][k] is sample k of channel ch
frame_valid  output  1  u holds a complete frame
frame_ack  input  1  consumer has latched u; frees the read bank
fill_level  output  clog2(N_SAMP)+1  samples written into the current write bank (0..N_SAMP)
frames_done  output  16  count of acknowledged frames, wraps at 65535 -> 0

Behaviour:
- Reset (rst=0, asynchronous):
  - Both banks EMPTY; wr_sel=0, rd_sel=0, write index=0.
  - s_ready=0 while reset is asserted; s_ready=1 from the first clock after release.
  - frame_valid=0, fill_level=0, frames_done=0.
  - Bank contents are not reset.
  - u is driven as 0 whenever frame_valid=0, so its reset value is 0.
- Beat accept: a vector is accepted on a rising edge with s_valid && s_ready.
  - s_data[ch] is written to bank[wr_sel][ch][idx]; idx increments.
  - fill_level equals idx, registered.
- Frame completion: the beat with idx=N_SAMP-1 marks bank[wr_sel] FULL, resets idx to 0 and toggles wr_sel. fill_level returns to 0.
- frame_valid asserts the cycle after the completing beat. Latency from last accepted beat to frame_valid is 1 clock.
- Write FSM:
  - FILL: s_ready = !full[wr_sel]. On completion go to FILL if the next bank is EMPTY, else STALL.
  - STALL (both banks FULL): s_ready=0 and incoming data is ignored. Return to FILL the cycle after a frame_ack frees a bank.
- Read side:
  - frame_valid = full[rd_sel].
  - u = bank[rd_sel] while frame_valid=1, else 0.
  - u is stable for the whole frame_valid interval; no bank in FULL state is ever written.
- Ack:
  - frame_ack with frame_valid=1 clears full[rd_sel], toggles rd_sel and increments frames_done.
  - If the other bank is FULL, frame_valid stays high the next cycle with new u.
  - frame_ack with frame_valid=0 is ignored; no state change.
- Simultaneous completing beat and frame_ack: both take effect in the same edge, with no lost frame and no stall cycle.
  - Example: bank0 acked, bank1 filled. The next cycle has frame_valid=1 showing bank1, and wr_sel=0 EMPTY.
- Reset mid-fill discards the partial frame and any FULL banks; frames_done=0.
- No data is dropped: backpressure is the only flow control. The producer must hold s_data while s_valid && !s_ready.

Decomposition:
- Shared package ica_pkg (also used by pe2/pe2_33):
  - Constants W=32, N_CH=3, N_SAMP=64.
  - Typedefs sample_t (signed [W-1:0]), vec_t (sample_t [0:N_CH-1]), frame_t (sample_t [0:N_CH-1][0:N_SAMP-1]).
  - enum wr_state_t {FILL, STALL}.
- One sub-module, ica_frame_bank: a single N_CH x N_SAMP register bank with a write enable and index, plus a full flag that can be set and cleared. It is instantiated twice; the loader holds the pointers, FSM and counters.

Test Plan:
- Single frame: after reset, drive 64 beats with s_data={k, -k, 2k}, k=0..63, no ack -> frame_valid rises 1 cycle after beat 63. u[0][5]=5, u[1][5]=-5, u[2][63]=126. fill_level=0.
- Double-full stall: send 128 beats with no ack -> s_ready=0 from cycle after beat 127. Beat 128 is held and not written. Ack -> s_ready=1 next cycle; u now shows frame 2 (u[0][0]=64); frames_done=1.
- Simultaneous event: bank0 FULL, bank1 at idx 63; drive last beat and frame_ack in the same cycle -> next cycle frame_valid=1, u[0][0]=64, s_ready=1, fill_level=0.
- Spurious ack: frame_ack pulsed with frame_valid=0 -> frames_done stays 0 and rd_sel is unchanged; later frame still appears in bank0.
- Reset mid-fill: 40 beats accepted, assert rst for 2 cycles -> frame_valid=0, u=0, fill_level=0. Then 64 fresh beats produce a frame starting with the new data only.
- Streaming throughput: continuous s_valid with frame_ack issued the cycle frame_valid rises, for 10 frames -> s_ready never drops, frames_done=10, every u[ch][k] matches its reference.
